// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: arbiter FSM state encodings
package sram_port_arbiter_pkg;
  localparam logic [2:0] ARB_IDLE   = 3'd0;
  localparam logic [2:0] ARB_I_ADDR = 3'd1;
  localparam logic [2:0] ARB_I_DATA = 3'd2;
  localparam logic [2:0] ARB_D_ADDR = 3'd3;
  localparam logic [2:0] ARB_D_DATA = 3'd4;
endpackage

// File: rtl/sram_port_arbiter_tracker.sv
// sram_req_tracker: per-side done flag, read-data register and pending/stall
module sram_req_tracker #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          longest_stall,
  input  logic          fin,
  input  logic          wr_rdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic          pend
);
  logic done;
  assign pend = en & ~done;
  always_ff @(posedge clk) begin
    if (!rst) begin
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      done <= (fin & en) | (done & longest_stall);
      if (fin & wr_rdata) rdata <= mem_rdata;
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-outstanding memory port between fetch and load/store
module sram_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_en,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            i_stall,
  input  logic            data_en,
  input  logic [DW/8-1:0] data_wen,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            d_stall,
  input  logic            longest_stall,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata
);
  import sram_port_arbiter_pkg::*;
  logic [2:0] state;
  logic i_pend, d_pend;
  logic in_addr, in_data;
  assign in_addr = (state == ARB_I_ADDR) || (state == ARB_D_ADDR);
  assign in_data = (state == ARB_I_DATA) || (state == ARB_D_DATA);
  assign i_stall = i_pend;
  assign d_stall = d_pend;
  sram_req_tracker #(.DW(DW)) u_inst (
    .clk(clk), .rst(rst), .en(inst_en), .longest_stall(longest_stall),
    .fin((state == ARB_I_DATA) && mem_data_ok), .wr_rdata(1'b1),
    .mem_rdata(mem_rdata), .rdata(inst_rdata), .pend(i_pend)
  );
  sram_req_tracker #(.DW(DW)) u_data (
    .clk(clk), .rst(rst), .en(data_en), .longest_stall(longest_stall),
    .fin((state == ARB_D_DATA) && mem_data_ok), .wr_rdata(~mem_wr),
    .mem_rdata(mem_rdata), .rdata(data_rdata), .pend(d_pend)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == ARB_IDLE && d_pend) begin
      state     <= ARB_D_ADDR;
      mem_req   <= 1'b1;
      mem_wr    <= |data_wen;
      mem_wstrb <= data_wen;
      mem_addr  <= data_addr;
      mem_wdata <= data_wdata;
    end else if (state == ARB_IDLE && i_pend) begin
      state     <= ARB_I_ADDR;
      mem_req   <= 1'b1;
      mem_wr    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= inst_addr;
      mem_wdata <= '0;
    end else if (in_addr && mem_addr_ok) begin
      state   <= state + 3'd1;
      mem_req <= 1'b0;
    end else if (in_data && mem_data_ok) begin
      state <= ARB_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    assert (!(rst && mem_data_ok && !in_data)) else $error("mem_data_ok outside a data phase");
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed vector bench for sram_port_arbiter
module tb_sram_port_arbiter;
  logic clk, rst;
  logic inst_en, data_en, ext_stall;
  logic [31:0] inst_addr, data_addr, data_wdata, inst_rdata, data_rdata;
  logic [3:0] data_wen, mem_wstrb;
  logic i_stall, d_stall, longest_stall;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int checks = 0, errors = 0;
  int aw_lat = 0, dw_lat = 0;
  logic [31:0] acc_log[$];
  typedef struct {
    logic        is_data;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    int          exp_stall;
    int          exp_req;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];
  assign longest_stall = ext_stall | i_stall | d_stall;
  sram_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .d_stall(d_stall), .longest_stall(longest_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'hBFC00000) ? 32'h3C080001 : (a ^ 32'h12345678);
  endfunction
  int cnt = 0;
  logic inflight = 0;
  logic [31:0] cur_addr = 0;
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      inflight = 0;
      cnt = 0;
      mem_addr_ok = 0;
      mem_data_ok = 0;
    end else begin
      if (mem_addr_ok) begin
        inflight = 1;
        cnt = 0;
      end
      if (mem_data_ok) begin
        inflight = 0;
        cnt = 0;
      end
      mem_addr_ok = 0;
      mem_data_ok = 0;
      if (inflight) begin
        if (cnt >= dw_lat) begin
          mem_data_ok = 1;
          mem_rdata = mem_word(cur_addr);
        end else cnt++;
      end else if (mem_req) begin
        if (cnt >= aw_lat) begin
          mem_addr_ok = 1;
          cur_addr = mem_addr;
          acc_log.push_back(mem_addr);
        end else cnt++;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int n, reqc;
    logic stable;
    aw_lat = v.aw;
    dw_lat = v.dw;
    acc_log.delete();
    @(negedge clk);
    if (v.is_data) begin
      data_en = 1;
      data_wen = v.wen;
      data_addr = v.addr;
      data_wdata = v.wdata;
    end else begin
      inst_en = 1;
      inst_addr = v.addr;
    end
    #1;
    n = 0;
    reqc = 0;
    stable = 1;
    while ((v.is_data ? d_stall : i_stall) && n < 100) begin
      n++;
      if (mem_req) begin
        reqc++;
        if (mem_addr !== v.addr || mem_wdata !== v.wdata || mem_wstrb !== v.wen || mem_wr !== (|v.wen))
          stable = 0;
      end
      @(negedge clk);
      #1;
    end
    inst_en = 0;
    data_en = 0;
    chk("vec_stall_cycles", n, v.exp_stall);
    chk("vec_req_cycles", reqc, v.exp_req);
    chk("vec_fields_stable", {31'd0, stable}, 1);
    chk("vec_accepts", acc_log.size(), 1);
    chk("vec_accept_addr", acc_log.size() > 0 ? acc_log[0] : 32'hXXXXXXXX, v.addr);
    chk("vec_rdata", v.is_data ? data_rdata : inst_rdata, v.exp_rdata);
    chk("vec_mem_wr", {31'd0, mem_wr}, {31'd0, |v.wen});
  endtask
  initial begin
    int n, d_fall, i_fall;
    logic ok;
    logic [31:0] r0;
    vecs[0] = '{1'b0, 4'b0000, 32'hBFC00000, 32'h0,        0, 0, 3, 1, 32'h3C080001};
    vecs[1] = '{1'b1, 4'b0000, 32'h80001000, 32'h0,        1, 2, 6, 2, 32'h92344678};
    vecs[2] = '{1'b1, 4'b0011, 32'h80000004, 32'h0000BEEF, 4, 0, 7, 5, 32'h92344678};
    vecs[3] = '{1'b0, 4'b0000, 32'hBFC00004, 32'h0,        2, 1, 6, 3, 32'hADF4567C};
    vecs[4] = '{1'b1, 4'b0000, 32'h80000008, 32'h0,        0, 0, 3, 1, 32'h92345670};
    vecs[5] = '{1'b1, 4'b1111, 32'h80000010, 32'hDEADBEEF, 0, 1, 4, 1, 32'h92345670};
    rst = 0;
    inst_en = 0;
    data_en = 0;
    ext_stall = 0;
    inst_addr = 0;
    data_addr = 0;
    data_wen = 0;
    data_wdata = 0;
    mem_addr_ok = 0;
    mem_data_ok = 0;
    mem_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_fields", {27'd0, mem_wr, mem_wstrb}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", inst_rdata | data_rdata, 0);
    chk("rst_stalls_idle", {30'd0, i_stall, d_stall}, 0);
    inst_en = 1;
    data_en = 1;
    #1;
    chk("rst_pend_stalls", {30'd0, i_stall, d_stall}, 32'd3);
    @(negedge clk);
    inst_en = 0;
    data_en = 0;
    rst = 1;
    foreach (vecs[i]) run_vec(vecs[i]);
    // simultaneous fetch and load: data goes first
    aw_lat = 0;
    dw_lat = 0;
    acc_log.delete();
    @(negedge clk);
    inst_en = 1;
    inst_addr = 32'hBFC00004;
    data_en = 1;
    data_wen = 0;
    data_addr = 32'h80001000;
    data_wdata = 0;
    #1;
    n = 0;
    d_fall = -1;
    i_fall = -1;
    while (n < 100 && (d_fall < 0 || i_fall < 0)) begin
      if (!d_stall && d_fall < 0) d_fall = n;
      if (!i_stall && i_fall < 0) i_fall = n;
      if (d_fall < 0 || i_fall < 0) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    inst_en = 0;
    data_en = 0;
    chk("sim_d_fall", d_fall, 3);
    chk("sim_i_fall", i_fall, 6);
    chk("sim_accepts", acc_log.size(), 2);
    chk("sim_first_addr", acc_log.size() > 0 ? acc_log[0] : 32'hXXXXXXXX, 32'h80001000);
    chk("sim_second_addr", acc_log.size() > 1 ? acc_log[1] : 32'hXXXXXXXX, 32'hBFC00004);
    chk("sim_data_rdata", data_rdata, 32'h92344678);
    chk("sim_inst_rdata", inst_rdata, 32'hADF4567C);
    // global stall holds done and rdata
    acc_log.delete();
    @(negedge clk);
    inst_en = 1;
    inst_addr = 32'hBFC00000;
    #1;
    n = 0;
    while (i_stall && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("gs_stall_cycles", n, 3);
    ext_stall = 1;
    r0 = inst_rdata;
    ok = 1;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (i_stall || mem_req || inst_rdata !== r0) ok = 0;
    end
    chk("gs_hold", {31'd0, ok}, 1);
    chk("gs_rdata", r0, 32'h3C080001);
    @(negedge clk);
    ext_stall = 0;
    #1;
    chk("gs_done_held", {31'd0, i_stall}, 0);
    @(negedge clk);
    #1;
    chk("gs_done_cleared", {31'd0, i_stall}, 1);
    chk("gs_no_extra_req", acc_log.size(), 1);
    n = 0;
    while (i_stall && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    inst_en = 0;
    chk("gs_refetch_cycles", n, 3);
    // fetch flushed during I_DATA
    aw_lat = 0;
    dw_lat = 2;
    acc_log.delete();
    @(negedge clk);
    inst_en = 1;
    inst_addr = 32'hBFC00000;
    repeat (3) @(negedge clk);
    inst_en = 0;
    repeat (2) @(negedge clk);
    dw_lat = 0;
    inst_en = 1;
    inst_addr = 32'hBFC00380;
    #1;
    chk("fl_no_done", {31'd0, i_stall}, 1);
    n = 0;
    while (i_stall && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    inst_en = 0;
    chk("fl_new_cycles", n, 3);
    chk("fl_accepts", acc_log.size(), 2);
    chk("fl_new_addr", acc_log.size() > 1 ? acc_log[1] : 32'hXXXXXXXX, 32'hBFC00380);
    chk("fl_rdata", inst_rdata, 32'hADF455F8);
    // reset during D_DATA
    aw_lat = 0;
    dw_lat = 3;
    @(negedge clk);
    data_en = 1;
    data_wen = 0;
    data_addr = 32'h80001000;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk("rs_mem_req", {31'd0, mem_req}, 0);
    chk("rs_mem_fields", {27'd0, mem_wr, mem_wstrb}, 0);
    chk("rs_mem_addr", mem_addr, 0);
    chk("rs_mem_wdata", mem_wdata, 0);
    chk("rs_inst_rdata", inst_rdata, 0);
    chk("rs_data_rdata", data_rdata, 0);
    chk("rs_d_not_done", {31'd0, d_stall}, 1);
    rst = 1;
    data_en = 0;
    #1;
    chk("rs_d_idle", {31'd0, d_stall}, 0);
    run_vec(vecs[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
